// File: rtl/pe_verify_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pe_verify_scheduler
// Description : Steps the 16:1 PE test-mux select through one PE or a masked
//               sweep, with settle, dwell and capture-handshake phases.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_verify_scheduler #(
   parameter int SETTLE_CYC = 2,
   parameter int DWELL_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic               loop_en,
   input  logic [3:0]         single_sel,
   input  logic [15:0]        pe_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               cap_ready,
   output logic [3:0]         pe_verify_sel,
   output logic               sel_valid,
   output logic               cap_req,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [7:0]         pass_cnt
);

   localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

   localparam logic [2:0] C_IDLE    = 3'd0;
   localparam logic [2:0] C_SETTLE  = 3'd1;
   localparam logic [2:0] C_DWELL   = 3'd2;
   localparam logic [2:0] C_CAPTURE = 3'd3;
   localparam logic [2:0] C_DONE    = 3'd4;

   localparam logic [CNT_W-1:0]   C_CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   C_SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [DWELL_W-1:0] C_DWELL_ONE  = DWELL_W'(1);

   logic [2:0]         state_q, state_d;
   logic [3:0]         sel_q, sel_d;
   logic               mode_q, mode_d;
   logic               loop_q, loop_d;
   logic [15:0]        mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         pass_q, pass_d;
   logic               aborted_q, aborted_d;

   logic [15:0]        w_hi_mask;
   logic               w_has_next;

   function automatic logic [3:0] f_lowest(input logic [15:0] m);
      f_lowest = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) f_lowest = 4'(i);
      end
   endfunction

   // Enabled PEs strictly above the current select, for the next sweep step.
   always_comb begin
      w_hi_mask = 16'd0;
      for (int i = 0; i < 16; i++) begin
         w_hi_mask[i] = mask_q[i] && (i > int'(sel_q));
      end
   end
   assign w_has_next = |w_hi_mask;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      mode_d    = mode_q;
      loop_d    = loop_q;
      mask_d    = mask_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      aborted_d = 1'b0;
      case (state_q)
         C_IDLE: begin
            if (start && !(mode && (pe_mask == 16'd0))) begin
               mode_d  = mode;
               loop_d  = loop_en;
               mask_d  = pe_mask;
               dwell_d = (dwell == '0) ? C_DWELL_ONE : dwell;
               pass_d  = 8'd0;
               sel_d   = mode ? f_lowest(pe_mask) : single_sel;
               cnt_d   = C_SETTLE_LD;
               state_d = C_SETTLE;
            end
         end
         C_SETTLE: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(dwell_q) - C_CNT_ONE;
               state_d = C_DWELL;
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end
         C_DWELL: begin
            if (cnt_q == '0) state_d = C_CAPTURE;
            else             cnt_d   = cnt_q - C_CNT_ONE;
         end
         C_CAPTURE: begin
            if (cap_ready) begin
               cnt_d = C_SETTLE_LD;
               if (!mode_q) begin
                  state_d = C_DONE;
               end else if (w_has_next) begin
                  sel_d   = f_lowest(w_hi_mask);
                  state_d = C_SETTLE;
               end else begin
                  pass_d = pass_q + 8'd1;
                  if (loop_q) begin
                     sel_d   = f_lowest(mask_q);
                     state_d = C_SETTLE;
                  end else begin
                     state_d = C_DONE;
                  end
               end
            end
         end
         C_DONE:  state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
      // Abort wins over any handshake completing in the same cycle.
      if (stop && (state_q != C_IDLE)) begin
         state_d   = C_IDLE;
         sel_d     = sel_q;
         pass_d    = pass_q;
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= C_IDLE;
         sel_q     <= 4'd0;
         mode_q    <= 1'b0;
         loop_q    <= 1'b0;
         mask_q    <= 16'd0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         pass_q    <= 8'd0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         mode_q    <= mode_d;
         loop_q    <= loop_d;
         mask_q    <= mask_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
         pass_q    <= pass_d;
         aborted_q <= aborted_d;
      end
   end

   assign pe_verify_sel = sel_q;
   assign sel_valid     = (state_q == C_DWELL) || (state_q == C_CAPTURE);
   assign cap_req       = (state_q == C_CAPTURE);
   assign busy          = (state_q != C_IDLE);
   assign done          = (state_q == C_DONE);
   assign aborted       = aborted_q;
   assign pass_cnt      = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_verify_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_verify_scheduler
// Description : Randomized self-checking bench; expected timelines are built
//               from the PE visit list implied by mode/mask/loop settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_verify_scheduler;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst, start, stop, mode, loop_en, cap_ready;
   logic [3:0]  single_sel;
   logic [15:0] pe_mask;
   logic [7:0]  dwell;
   logic [3:0]  pe_verify_sel;
   logic        sel_valid, cap_req, busy, done, aborted;
   logic [7:0]  pass_cnt;

   int tests = 0;
   int fails = 0;

   pe_verify_scheduler #(.SETTLE_CYC(SETTLE), .DWELL_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .loop_en(loop_en), .single_sel(single_sel), .pe_mask(pe_mask),
      .dwell(dwell), .cap_ready(cap_ready), .pe_verify_sel(pe_verify_sel),
      .sel_valid(sel_valid), .cap_req(cap_req), .busy(busy), .done(done),
      .aborted(aborted), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      mode       = 1'($urandom);
      loop_en    = 1'($urandom);
      single_sel = 4'($urandom);
      pe_mask    = 16'($urandom);
      dwell      = 8'($urandom);
   endtask

   // bp < 0 : random capture backpressure per PE, otherwise fixed wait cycles
   task automatic do_run(input logic m, input logic lp, input logic [3:0] ss,
                         input logic [15:0] mk, input logic [7:0] dw,
                         input int max_visits, input int bp);
      int q[$];
      int idx, visit, pass, eff_dw, w, pe;
      q = {};
      if (!m) q.push_back(int'(ss));
      else for (int i = 0; i < 16; i++) if (mk[i]) q.push_back(i);
      mode = m; loop_en = lp; single_sel = ss; pe_mask = mk; dwell = dw;
      start = 1'b1;
      step();
      start = 1'b0;
      if (q.size() == 0) begin
         chk("mask0_busy", 32'(busy), 32'd0);
         step();
         chk("mask0_busy2", 32'(busy), 32'd0);
         return;
      end
      scramble();
      eff_dw = (dw == 8'd0) ? 1 : int'(dw);
      idx = 0; visit = 0; pass = 0; pe = q[0];
      forever begin
         pe = q[idx];
         for (int s = 0; s < SETTLE; s++) begin
            chk("settle_sel", 32'(pe_verify_sel), 32'(pe));
            chk("settle_valid", 32'(sel_valid), 32'd0);
            chk("settle_busy", 32'(busy), 32'd1);
            chk("settle_pass", 32'(pass_cnt), 32'(pass));
            cap_ready = 1'($urandom);
            step();
         end
         for (int d = 0; d < eff_dw; d++) begin
            chk("dwell_sel", 32'(pe_verify_sel), 32'(pe));
            chk("dwell_valid", 32'(sel_valid), 32'd1);
            chk("dwell_capreq", 32'(cap_req), 32'd0);
            cap_ready = 1'($urandom);
            step();
         end
         w = (bp < 0) ? int'($urandom_range(0, 4)) : bp;
         cap_ready = 1'b0;
         for (int k = 0; k < w; k++) begin
            chk("bp_capreq", 32'(cap_req), 32'd1);
            chk("bp_sel", 32'(pe_verify_sel), 32'(pe));
            chk("bp_valid", 32'(sel_valid), 32'd1);
            step();
         end
         chk("cap_capreq", 32'(cap_req), 32'd1);
         chk("cap_sel", 32'(pe_verify_sel), 32'(pe));
         cap_ready = 1'b1;
         step();
         cap_ready = 1'b0;
         visit++; idx++;
         if (idx == q.size()) begin
            if (m) pass = (pass + 1) % 256;
            if (m && lp) idx = 0;
            else break;
         end
         if (m && lp && visit >= max_visits) begin
            chk("pre_stop_sel", 32'(pe_verify_sel), 32'(q[idx]));
            chk("pre_stop_pass", 32'(pass_cnt), 32'(pass));
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk("stop_busy", 32'(busy), 32'd0);
            chk("stop_aborted", 32'(aborted), 32'd1);
            chk("stop_done", 32'(done), 32'd0);
            chk("stop_valid", 32'(sel_valid), 32'd0);
            step();
            chk("stop_aborted_end", 32'(aborted), 32'd0);
            chk("stop_done_end", 32'(done), 32'd0);
            return;
         end
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_capreq", 32'(cap_req), 32'd0);
      chk("done_pass", 32'(pass_cnt), 32'(pass));
      step();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sel_hold", 32'(pe_verify_sel), 32'(pe));
      chk("idle_aborted", 32'(aborted), 32'd0);
   endtask

   task automatic wait_capreq(input string tag);
      for (int k = 0; k < 40 && !cap_req; k++) step();
      chk(tag, 32'(cap_req), 32'd1);
   endtask

   initial begin
      logic m, lp;
      logic [15:0] mk;
      rst = 1'b1; start = 1'b0; stop = 1'b0; cap_ready = 1'b0;
      mode = 1'b0; loop_en = 1'b0; single_sel = 4'd0; pe_mask = 16'd0; dwell = 8'd0;
      repeat (3) step();
      chk("rst_sel", 32'(pe_verify_sel), 32'd0);
      chk("rst_valid", 32'(sel_valid), 32'd0);
      chk("rst_capreq", 32'(cap_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_aborted", 32'(aborted), 32'd0);
      chk("rst_pass", 32'(pass_cnt), 32'd0);
      rst = 1'b0;
      step();

      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("idle_stop_busy", 32'(busy), 32'd0);
      chk("idle_stop_aborted", 32'(aborted), 32'd0);

      do_run(1'b0, 1'b0, 4'hA, 16'h0000, 8'd3, 0, 0);
      do_run(1'b1, 1'b0, 4'h0, 16'h8421, 8'd1, 0, 0);
      do_run(1'b1, 1'b0, 4'h0, 16'h8421, 8'd2, 0, 5);
      do_run(1'b1, 1'b1, 4'h0, 16'h0003, 8'd1, 7, 0);
      do_run(1'b1, 1'b0, 4'h0, 16'h0000, 8'd1, 0, 0);
      do_run(1'b0, 1'b0, 4'h3, 16'h0000, 8'd0, 0, 0);

      // stop and cap_ready together in CAPTURE: abort, no further PE selected
      mode = 1'b1; loop_en = 1'b1; pe_mask = 16'h0006; dwell = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_capreq("stopcap_reach");
      stop = 1'b1; cap_ready = 1'b1;
      step();
      stop = 1'b0; cap_ready = 1'b0;
      chk("stopcap_busy", 32'(busy), 32'd0);
      chk("stopcap_aborted", 32'(aborted), 32'd1);
      chk("stopcap_sel", 32'(pe_verify_sel), 32'd1);
      chk("stopcap_valid", 32'(sel_valid), 32'd0);
      step();

      // reset in the middle of DWELL
      mode = 1'b0; single_sel = 4'hA; dwell = 8'd6;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 10 && !sel_valid; k++) step();
      chk("rstdw_reach", 32'(sel_valid), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstdw_sel", 32'(pe_verify_sel), 32'd0);
      chk("rstdw_valid", 32'(sel_valid), 32'd0);
      chk("rstdw_busy", 32'(busy), 32'd0);
      chk("rstdw_capreq", 32'(cap_req), 32'd0);
      chk("rstdw_done", 32'(done), 32'd0);
      chk("rstdw_aborted", 32'(aborted), 32'd0);
      chk("rstdw_pass", 32'(pass_cnt), 32'd0);

      repeat (25) begin
         m  = 1'($urandom);
         lp = 1'($urandom);
         mk = 16'($urandom & $urandom);
         if ($urandom_range(0, 7) == 0) mk = 16'd0;
         do_run(m, lp, 4'($urandom), mk, 8'($urandom_range(0, 4)),
                int'($urandom_range(1, 8)), -1);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
